// File: rtl/restador_pkg.sv
`default_nettype none
// restador_pkg: state encoding, default width and digit-count helpers for restador_serial.
package restador_pkg;

  localparam int RES_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit digit_ok(input int width, input int digit_w);
    return (digit_w > 0) && (width >= digit_w) && ((width % digit_w) == 0);
  endfunction

  // Number of RUN cycles per operation; illegal splits are trapped at elaboration by the top.
  function automatic int calc_n(input int width, input int digit_w);
    return digit_ok(width, digit_w) ? (width / digit_w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/restador_digito.sv
`default_nettype none
// restador_digito: combinational DIGIT_W-bit subtract cell with borrow in/out.
module restador_digito
  import restador_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  // One extra bit catches the borrow: a negative digit difference wraps into the top bit.
  logic [DIGIT_W:0] diff;

  assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
  assign d    = diff[DIGIT_W-1:0];
  assign bout = diff[DIGIT_W];

endmodule
`default_nettype wire

// File: rtl/restador_serial.sv
`default_nettype none
// restador_serial: multi-cycle C = A - B, DIGIT_W bits per clock, LSB first, with start/done handshake.
// Optional macro RESTADOR_OVF_EN adds the signed-overflow output ovf.
module restador_serial
  import restador_pkg::*;
#(
  parameter int WIDTH   = RES_WIDTH_DEF,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             borrow,
  output logic             zero
`ifdef RESTADOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = calc_n(WIDTH, DIGIT_W);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!digit_ok(WIDTH, DIGIT_W)) begin : g_bad_digit
      $error("restador_serial: DIGIT_W must divide WIDTH");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res_sh;
  logic [WIDTH-1:0]   res_next;
  logic [DIGIT_W-1:0] d;
  logic               bin_q;
  logic               bout;
  logic               last_digit;

`ifdef RESTADOR_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  restador_digito #(
    .DIGIT_W (DIGIT_W)
  ) u_digito (
    .a    (a_sh[DIGIT_W-1:0]),
    .b    (b_sh[DIGIT_W-1:0]),
    .bin  (bin_q),
    .d    (d),
    .bout (bout)
  );

  // Difference digits enter from the MSB side so that after N shifts the LSB digit sits at bit 0.
  generate
    if (DIGIT_W == WIDTH) begin : g_res_single
      assign res_next = d;
    end else begin : g_res_shift
      assign res_next = {d, res_sh[WIDTH-1:DIGIT_W]};
    end
  endgenerate

  assign last_digit = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bin_q  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      C      <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef RESTADOR_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
            state  <= ST_RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
`ifdef RESTADOR_OVF_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          res_sh <= res_next;
          bin_q  <= bout;
          cnt    <= cnt + 1'b1;
          if (last_digit) begin
            state  <= ST_DONE;
            C      <= res_next;
            borrow <= bout;
            zero   <= (res_next == '0);
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
`ifdef RESTADOR_OVF_EN
            ovf    <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_restador_serial.sv
`default_nettype none
// Scoreboard bench: two restador_serial instances (DIGIT_W=1 and DIGIT_W=4) against an arithmetic model.
module tb_restador_serial;

  localparam int W   = 16;
  localparam int DW0 = 1;
  localparam int DW1 = 4;

  typedef struct {
    int         inst;
    logic [W-1:0] c;
    bit         brw;
    bit         z;
    bit         ov;
    int         due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         st0 = 1'b0, st1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         rdy0, bsy0, dn0, brw0, z0, ov0;
  logic         rdy1, bsy1, dn1, brw1, z1, ov1;
  logic [W-1:0] c0, c1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  logic [W-1:0] last_c [2];
  bit           last_b [2];
  bit           last_z [2];
  bit           last_o [2];
  int           bstart [2];
  int           bend   [2];

  restador_serial #(.WIDTH(W), .DIGIT_W(DW0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st0), .A(a0), .B(b0),
    .ready(rdy0), .busy(bsy0), .done(dn0), .C(c0), .borrow(brw0), .zero(z0)
`ifdef RESTADOR_OVF_EN
    , .ovf(ov0)
`endif
  );

  restador_serial #(.WIDTH(W), .DIGIT_W(DW1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1),
    .ready(rdy1), .busy(bsy1), .done(dn1), .C(c1), .borrow(brw1), .zero(z1)
`ifdef RESTADOR_OVF_EN
    , .ovf(ov1)
`endif
  );

`ifndef RESTADOR_OVF_EN
  assign ov0 = 1'b0;
  assign ov1 = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int nd(input int i);
    return (i == 0) ? W / DW0 : W / DW1;
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    int   ua, ub, diff, sa, sb, sd;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    diff = ua - ub;
    sd = sa - sb;
    e.inst = i;
    e.due  = due;
    e.brw  = (diff < 0);
    e.c    = W'((diff < 0) ? diff + 65536 : diff);
    e.z    = (e.c == 0);
    e.ov   = (sd > 32767) || (sd < -32768);
    return e;
  endfunction

  function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %0h, want %0h", nm, i, cyc, act, exp);
    end
  endfunction

  function automatic int pending(input int i);
    int n = 0;
    foreach (sbq[j]) if (sbq[j].inst == i) n++;
    return n;
  endfunction

  task automatic mon(input int i, input logic rdy, input logic bsy, input logic dn,
                     input logic [W-1:0] c, input logic brw, input logic z, input logic o);
    bit exp_busy;
    int idx;
    exp_busy = (cyc >= bstart[i]) && (cyc <= bend[i]);
    idx = -1;
    chk("busy", i, bsy, exp_busy);
    chk("ready", i, rdy, !exp_busy);
    for (int j = 0; j < sbq.size(); j++)
      if (sbq[j].inst == i && idx < 0) idx = j;
    if (dn) begin
      if (idx < 0) begin
        chk("spurious_done", i, dn, 1'b0);
      end else begin
        chk("done_cycle", i, cyc, sbq[idx].due);
        last_c[i] = sbq[idx].c;
        last_b[i] = sbq[idx].brw;
        last_z[i] = sbq[idx].z;
        last_o[i] = sbq[idx].ov;
        sbq.delete(idx);
      end
    end else if (idx >= 0 && cyc > sbq[idx].due) begin
      chk("missing_done", i, dn, 1'b1);
      sbq.delete(idx);
    end
    chk("C", i, c, last_c[i]);
    chk("borrow", i, brw, last_b[i]);
    chk("zero", i, z, last_z[i]);
`ifdef RESTADOR_OVF_EN
    chk("ovf", i, o, last_o[i]);
`endif
  endtask

  always @(negedge clk) begin
    mon(0, rdy0, bsy0, dn0, c0, brw0, z0, ov0);
    mon(1, rdy1, bsy1, dn1, c1, brw1, z1, ov1);
  end

  // Drives a one-cycle start; the model only expects a result if the DUT is ready for it.
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    logic r;
    @(posedge clk); #2;
    if (i == 0) begin st0 = 1'b1; a0 = a; b0 = b; r = rdy0; end
    else        begin st1 = 1'b1; a1 = a; b1 = b; r = rdy1; end
    if (r === 1'b1) begin
      sbq.push_back(model(i, a, b, cyc + 1 + nd(i)));
      bstart[i] = cyc + 1;
      bend[i]   = cyc + nd(i);
    end
    @(posedge clk); #2;
    if (i == 0) begin st0 = 1'b0; a0 = W'($urandom); b0 = W'($urandom); end
    else        begin st1 = 1'b0; a1 = W'($urandom); b1 = W'($urandom); end
  endtask

  task automatic drain(input int i);
    int budget = 0;
    while (pending(i) > 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #2;
    chk("drain", i, pending(i), 0);
  endtask

  task automatic wait_due(input int i);
    int d = -1;
    foreach (sbq[j]) if (sbq[j].inst == i && d < 0) d = sbq[j].due;
    while (d >= 0 && cyc < d - 1) @(posedge clk);
  endtask

  task automatic model_reset();
    sbq.delete();
    for (int i = 0; i < 2; i++) begin
      last_c[i] = '0; last_b[i] = 0; last_z[i] = 0; last_o[i] = 0;
      bstart[i] = 1;  bend[i] = 0;
    end
  endtask

  task automatic random_ops(input int i, input int count);
    logic [W-1:0] a, b;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = '0;
        2: b = '1;
        default: ;
      endcase
      issue(i, a, b);
    end
    drain(i);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases on the bit-serial instance
    issue(0, 16'd5, 16'd3);          drain(0);
    issue(0, 16'd0, 16'd1);          drain(0);
    issue(0, 16'h1234, 16'h1234);    drain(0);
    issue(0, 16'h8000, 16'h0001);    drain(0);
    issue(0, 16'd3, 16'd1);          drain(0);

    // start during RUN is ignored, then a back-to-back start in the DONE cycle
    issue(0, 16'd3, 16'd1);
    repeat (3) @(posedge clk);
    issue(0, 16'd9, 16'd9);
    wait_due(0);
    issue(0, 16'h00F0, 16'h0F00);
    drain(0);

    // Reset in the middle of RUN aborts with no done pulse
    issue(0, 16'h0F0F, 16'h0101);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 16'h0100, 16'h0001);    drain(0);

    // Four-bit digit instance
    issue(1, 16'h1000, 16'h0001);    drain(1);
    issue(1, 16'h0000, 16'h0001);    drain(1);
    issue(1, 16'h8000, 16'h0001);
    wait_due(1);
    issue(1, 16'h4321, 16'h4321);    drain(1);

    random_ops(0, 40);
    random_ops(1, 60);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
